// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch / program-counter stage of the MIPS single-cycle core.
//   It fetches one instruction word from a memory that may insert wait states.
//   It holds that word stable for one execute cycle. It then advances the PC
//   from the controller's PCSrc/Jalr/branch decision and counts committed
//   instructions.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   imem_req/imem_addr   : fetch request and address (address == pc)
//   imem_ack/imem_rdata  : memory handshake and instruction word
//   inst, inst_valid     : latched instruction and execute-cycle strobe
//   PCSrc, Jalr, branch  : controller decision for the current inst
//   rs_data              : register read port 1, jr target
//   stall                : hold the execute cycle
//   pc, pc_plus4         : current instruction address and link value
//   retired              : committed instruction count (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        PCSrc,
    input  logic        Jalr,
    input  logic        branch,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic [31:0] retired_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] next_pc_s;
    logic        capture_s;
    logic        commit_s;
    logic        imem_req_s;
    logic        inst_valid_s;
    logic        unused_s;

    // Sign-extended 16-bit branch immediate, scaled to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // jr targets are word aligned, so the low two register bits are dropped.
    assign unused_s = ^rs_data[1:0];

    assign pc_plus4_s = pc_r + 32'd4;

    // Next-PC selection: sequential, jr, branch, then j/jal region jump.
    always_comb begin
        next_pc_s = pc_plus4_s;
        if (!PCSrc) begin
            next_pc_s = pc_plus4_s;
        end else if (Jalr) begin
            next_pc_s = {rs_data[31:2], 2'b00};
        end else if (branch) begin
            next_pc_s = pc_plus4_s + branch_offset(inst_r[15:0]);
        end else begin
            next_pc_s = {pc_plus4_s[31:28], inst_r[25:0], 2'b00};
        end
    end

    // FSM next state and handshake outputs; rst masks the strobes immediately.
    always_comb begin
        next_state_s = state_r;
        imem_req_s   = 1'b0;
        inst_valid_s = 1'b0;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            FETCH: begin
                imem_req_s = ~rst;
                if (imem_ack) begin
                    capture_s    = 1'b1;
                    next_state_s = EXEC;
                end else begin
                    next_state_s = FETCH;
                end
            end
            EXEC: begin
                inst_valid_s = ~stall & ~rst;
                if (!stall) begin
                    commit_s     = 1'b1;
                    next_state_s = FETCH;
                end else begin
                    next_state_s = EXEC;
                end
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // State, instruction latch, PC and retire counter; reset abandons any fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FETCH;
            pc_r      <= RESET_PC;
            inst_r    <= 32'h0000_0000;
            retired_r <= 32'h0000_0000;
        end else begin
            state_r <= next_state_s;
            if (capture_s) begin
                inst_r <= imem_rdata;
            end
            if (commit_s) begin
                pc_r      <= next_pc_s;
                retired_r <= retired_r + 32'd1;
            end
        end
    end

    assign imem_req   = imem_req_s;
    assign imem_addr  = pc_r;
    assign inst       = inst_r;
    assign inst_valid = inst_valid_s;
    assign pc         = pc_r;
    assign pc_plus4   = pc_plus4_s;
    assign retired    = retired_r;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. A transaction-level reference model
//   (current pc, held instruction, retire count, "instruction in hand" flag)
//   predicts every output each cycle. Directed scenarios are followed by a
//   randomized run with random wait states, stalls, controller decisions and
//   resets.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] ADD_W  = 32'h0022_1820;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        PCSrc;
    logic        Jalr;
    logic        branch;
    logic [31:0] rs_data;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_retired;
    bit          m_exec;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid),
        .PCSrc(PCSrc), .Jalr(Jalr), .branch(branch),
        .rs_data(rs_data), .stall(stall),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Target address straight from the instruction-set rules.
    function automatic logic [31:0] model_next(input logic ps, input logic jr,
                                               input logic br, input logic [31:0] rs);
        logic [31:0] seq;
        logic [31:0] imm;
        seq = m_pc + 32'd4;
        imm = {{16{m_inst[15]}}, m_inst[15:0]};
        if (!ps)      return seq;
        else if (jr)  return rs & 32'hFFFF_FFFC;
        else if (br)  return seq + imm * 32'd4;
        else          return (seq & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) * 32'd4);
    endfunction

    task automatic model_reset();
        m_pc      = RST_PC;
        m_inst    = 32'h0000_0000;
        m_retired = 32'h0000_0000;
        m_exec    = 1'b0;
    endtask

    // One clock cycle: drive inputs, check every output, advance the model.
    task automatic step(input logic a, input logic [31:0] rd, input logic ps,
                        input logic jr, input logic br, input logic [31:0] rs,
                        input logic st, input logic r);
        @(negedge clk);
        imem_ack = a; imem_rdata = rd; PCSrc = ps; Jalr = jr; branch = br;
        rs_data = rs; stall = st; rst = r;
        #1;
        check_val("imem_req",   {31'd0, imem_req},   {31'd0, (!r && !m_exec)});
        check_val("inst_valid", {31'd0, inst_valid}, {31'd0, (!r && m_exec && !st)});
        check_val("imem_addr",  imem_addr, m_pc);
        check_val("pc",         pc,        m_pc);
        check_val("pc_plus4",   pc_plus4,  m_pc + 32'd4);
        check_val("inst",       inst,      m_inst);
        check_val("retired",    retired,   m_retired);
        if (r) begin
            model_reset();
        end else if (!m_exec) begin
            if (a) begin
                m_inst = rd;
                m_exec = 1'b1;
            end
        end else if (!st) begin
            m_pc      = model_next(ps, jr, br, rs);
            m_retired = m_retired + 32'd1;
            m_exec    = 1'b0;
        end
    endtask

    // Zero-wait fetch followed by one unstalled execute cycle.
    task automatic fetch_exec(input logic [31:0] w, input logic ps, input logic jr,
                              input logic br, input logic [31:0] rs);
        step(1'b1, w, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, ps, jr, br, rs, 1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] hold_pc;
    logic [31:0] hold_ret;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        imem_ack = 1'b0; imem_rdata = 32'd0; PCSrc = 1'b0; Jalr = 1'b0;
        branch = 1'b0; rs_data = 32'd0; stall = 1'b0; rst = 1'b1;
        model_reset();
        @(posedge clk);

        // Reset held two checked cycles, then the first request.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0,         1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("post_rst_req",  {31'd0, imem_req}, 32'd1);
        check_val("post_rst_addr", imem_addr, 32'd0);

        // Zero-wait sequential: three add words.
        for (int i = 0; i < 3; i++) fetch_exec(ADD_W, 1'b0, 1'b0, 1'b0, 32'd0);
        after_edge();
        check_val("seq_pc",      pc,      32'h0000_000C);
        check_val("seq_retired", retired, 32'd3);

        // Three wait states, then a spurious ack during a stalled EXEC.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            check_val("wait_req",  {31'd0, imem_req}, 32'd1);
            check_val("wait_addr", imem_addr, 32'h0000_000C);
        end
        step(1'b1, ADD_W, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        after_edge();
        check_val("spurious_inst", inst, ADD_W);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        after_edge();
        check_val("pc_at_beq", pc, 32'h0000_0010);

        // beq taken backwards, then not taken.
        fetch_exec(32'h1000_FFFE, 1'b1, 1'b0, 1'b1, 32'd0);
        after_edge();
        check_val("beq_taken", pc, 32'h0000_000C);
        fetch_exec(ADD_W, 1'b0, 1'b0, 1'b0, 32'd0);
        fetch_exec(32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 32'd0);
        after_edge();
        check_val("beq_not_taken", pc, 32'h0000_0014);

        // jr into the 0x4 region, then j and jr.
        fetch_exec(32'h0060_0008, 1'b1, 1'b1, 1'b0, 32'h4000_0013);
        after_edge();
        check_val("jr_region", pc, 32'h4000_0010);
        step(1'b1, 32'h0800_0100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        after_edge();
        check_val("j_link", pc_plus4, 32'h4000_0014);
        step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        after_edge();
        check_val("j_target", pc, 32'h4000_0400);
        fetch_exec(32'h0020_0008, 1'b1, 1'b1, 1'b0, 32'h0000_0123);
        after_edge();
        check_val("jr_target", pc, 32'h0000_0120);

        // Two stalled EXEC cycles, commit on the third.
        hold_pc  = m_pc;
        hold_ret = m_retired;
        step(1'b1, ADD_W, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
            check_val("stall_valid", {31'd0, inst_valid}, 32'd0);
        end
        after_edge();
        check_val("stall_pc",  pc,      hold_pc);
        check_val("stall_ret", retired, hold_ret);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("stall_commit", {31'd0, inst_valid}, 32'd1);
        after_edge();
        check_val("commit_ret", retired, hold_ret + 32'd1);

        // Reset while a fetch is pending and acked in the reset cycle.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        after_edge();
        check_val("rst_pc",   pc,      RST_PC);
        check_val("rst_inst", inst,    32'd0);
        check_val("rst_ret",  retired, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        check_val("rst_fetch", {31'd0, imem_req}, 32'd1);

        // PC wrap-around at the top of the address space.
        fetch_exec(32'h0020_0008, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
        after_edge();
        check_val("top_pc",   pc,       32'hFFFF_FFFC);
        check_val("wrap_p4",  pc_plus4, 32'h0000_0000);
        fetch_exec(ADD_W, 1'b0, 1'b0, 1'b0, 32'd0);
        after_edge();
        check_val("wrap_pc",  pc,       32'h0000_0000);

        // Randomized traffic: wait states, stalls, decisions, rare resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), $urandom(),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), $urandom(),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
